// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin arbiter driving a 4:1 mux into one registered output slot
module rr_mux_arbiter_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       src_q, src_d, last_q, last_d, win;
  logic             found, can_accept, xfer;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       idx;
  // search priority order last+1 .. last+4 for the first valid requester
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && in_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  assign can_accept = (state_q == EMPTY) | out_ready;
  assign xfer       = !rst && can_accept && found;
  assign in_ready   = xfer ? 4'(4'b0001 << win) : 4'b0000;
  assign sel_data   = win == 2'd0 ? d0 : win == 2'd1 ? d1 : win == 2'd2 ? d2 : d3;
  assign out_valid  = state_q == FULL;
  assign out_data   = data_q;
  assign out_src    = src_q;
  // load the winner on a transfer, otherwise drain or hold the slot
  always_comb begin
    state_d = xfer ? FULL : (state_q == FULL && out_ready) ? EMPTY : state_q;
    data_d  = xfer ? sel_data : data_q;
    src_d   = xfer ? win : src_q;
    last_d  = xfer ? win : last_q;
  end
  // output slot and priority pointer; last=3 after reset puts requester 0 first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end
endmodule
